// File: rtl/seq_muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM state codes and the R-type opcode decode used by MainControl.
package muldiv_pkg;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [3:0] RT_MULU = 4'b1010;
    localparam logic [3:0] RT_MUL  = 4'b1011;
    localparam logic [3:0] RT_DIVU = 4'b1100;
    localparam logic [3:0] RT_DIV  = 4'b1101;

    typedef struct packed {
        logic       valid;
        logic [1:0] op;
    } muldiv_dec_t;

    function automatic muldiv_dec_t decode_rtype(input logic [3:0] code);
        muldiv_dec_t dec;
        dec.valid = 1'b1;
        dec.op    = OP_MULU;
        case (code)
            RT_MULU: dec.op = OP_MULU;
            RT_MUL:  dec.op = OP_MUL;
            RT_DIVU: dec.op = OP_DIVU;
            RT_DIV:  dec.op = OP_DIV;
            default: dec.valid = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/seq_muldiv_unit_if.sv
// Request/result bundle between the EX stage (master) and the muldiv unit (slave).
interface seq_muldiv_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/seq_muldiv_unit_sign_cond.sv
// Conditional two's-complement negation, used to form magnitudes on entry
// and to restore result signs on completion.
module muldiv_sign_cond #(
    parameter int WIDTH = 16
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] din_n;

    assign din_n = ~din;
    assign dout  = neg ? (din_n + WIDTH'(1)) : din;
endmodule

// File: rtl/seq_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO results and a
// start/busy/done handshake; signed ops run on magnitudes with sign fix-up.
module seq_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic             clk,
    input logic             reset,
    seq_muldiv_unit_if.slave bus
);
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_r;
    logic             neg_res;
    logic             neg_rem;
    logic             dbz_pend;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    // acc holds {remainder/upper partial product (WIDTH+1), quotient/multiplier (WIDTH)}
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_step;

    logic             is_signed;
    logic             is_div;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic             accept;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;

    assign is_signed = bus.op[0];
    assign is_div    = bus.op[1];
    assign a_neg     = is_signed & bus.a[WIDTH-1];
    assign b_neg     = is_signed & bus.b[WIDTH-1];
    assign b_zero    = (bus.b == '0);
    assign accept    = (state == ST_IDLE) && bus.start;

    muldiv_sign_cond #(.WIDTH(WIDTH)) u_a_mag (
        .neg  (a_neg),
        .din  (bus.a),
        .dout (a_mag_in)
    );

    muldiv_sign_cond #(.WIDTH(WIDTH)) u_b_mag (
        .neg  (b_neg),
        .din  (bus.b),
        .dout (b_mag_in)
    );

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_diff;

    always_comb begin
        mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, b_mag};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_mag};
        acc_step = acc;
        if (op_r[1]) begin
            // restoring step: keep the difference only when it did not borrow
            if (!rem_diff[WIDTH]) begin
                acc_step = {rem_diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh, acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_step = {1'b0, mul_sum, acc[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc[2*WIDTH:WIDTH], acc[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] res_raw;
    logic [2*WIDTH-1:0] res_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign res_raw = op_r[1] ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc[2*WIDTH-1:0];

    muldiv_sign_cond #(.WIDTH(2*WIDTH)) u_res_fix (
        .neg  (neg_res),
        .din  (res_raw),
        .dout (res_fix)
    );

    muldiv_sign_cond #(.WIDTH(WIDTH)) u_rem_fix (
        .neg  (neg_rem),
        .din  (acc[2*WIDTH-1:WIDTH]),
        .dout (rem_fix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_r     <= OP_MULU;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dbz_pend <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_r    <= bus.op;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= is_div & a_neg;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        if (is_div && b_zero) begin
                            dbz_pend <= 1'b1;
                            state    <= ST_FINISH;
                        end else begin
                            dbz_pend <= 1'b0;
                            state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= ST_IDLE;
                    if (dbz_pend) begin
                        lo_r  <= '1;
                        hi_r  <= acc[WIDTH-1:0];
                        dbz_r <= 1'b1;
                    end else if (op_r[1]) begin
                        lo_r  <= res_fix[WIDTH-1:0];
                        hi_r  <= rem_fix;
                        dbz_r <= 1'b0;
                    end else begin
                        {hi_r, lo_r} <= res_fix;
                        dbz_r        <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // datapath registers carry no reset; the FSM decides when they are meaningful
    always_ff @(posedge clk) begin
        if (accept) begin
            b_mag <= b_mag_in;
            acc   <= (is_div && b_zero) ? {{(WIDTH+1){1'b0}}, bus.a}
                                        : {{(WIDTH+1){1'b0}}, a_mag_in};
        end else if (state == ST_CALC) begin
            acc <= acc_step;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Randomised and directed bench for seq_muldiv_unit against an arithmetic
// reference model (WIDTH=16).
module tb_seq_muldiv_unit;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_muldiv_unit_if #(.WIDTH(W)) bus();

    seq_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        longint p;
        int sa, sb, q, r;
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        if (op == 2'b00) begin
            p = longint'(a) * longint'(b);
            {hi, lo} = p[31:0];
        end else if (op == 2'b01) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {hi, lo} = p[31:0];
        end else if (b == '0) begin
            lo  = '1;
            hi  = a;
            dbz = 1'b1;
        end else if (op == 2'b10) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[15:0];
            hi = r[15:0];
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output logic busy_ok);
        bit seen;
        seen    = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                seen = 1'b1;
                lat  = i;
            end else if (!bus.busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ehi, elo;
        logic         edbz;
        int           lat;
        logic         busy_ok;
        model(op, a, b, ehi, elo, edbz);
        issue(op, a, b);
        check({name, ".busy_start"}, bus.busy, 1'b1);
        wait_done(lat, busy_ok);
        check({name, ".latency"}, lat, edbz ? 1 : W + 1);
        check({name, ".busy_hold"}, busy_ok, 1'b1);
        check({name, ".busy_at_done"}, bus.busy, 1'b0);
        check({name, ".hi"}, bus.hi, ehi);
        check({name, ".lo"}, bus.lo, elo);
        check({name, ".dbz"}, bus.div_by_zero, edbz);
    endtask

    initial begin
        logic [W-1:0] ehi, elo, ra, rb, hi_s, lo_s;
        logic         edbz;
        logic [1:0]   rop;
        int           n_done, n_busy;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset.busy", bus.busy, 1'b0);
        check("reset.done", bus.done, 1'b0);
        check("reset.hi", bus.hi, 16'h0000);
        check("reset.lo", bus.lo, 16'h0000);
        check("reset.dbz", bus.div_by_zero, 1'b0);

        run_op("mulu_max", 2'b00, 16'hFFFF, 16'hFFFF);
        check("mulu_max.hi_const", bus.hi, 16'hFFFE);
        check("mulu_max.lo_const", bus.lo, 16'h0001);
        run_op("mul_neg", 2'b01, 16'hFFFD, 16'h0005);
        check("mul_neg.lo_const", bus.lo, 16'hFFF1);
        run_op("div_neg", 2'b11, 16'hFFF9, 16'h0002);
        check("div_neg.lo_const", bus.lo, 16'hFFFD);
        check("div_neg.hi_const", bus.hi, 16'hFFFF);
        run_op("div_ovf", 2'b11, 16'h8000, 16'hFFFF);
        check("div_ovf.lo_const", bus.lo, 16'h8000);
        run_op("divu_zero", 2'b10, 16'h0064, 16'h0000);
        check("divu_zero.hi_const", bus.hi, 16'h0064);
        run_op("divu_after", 2'b10, 16'h0064, 16'h0007);
        check("divu_after.lo_const", bus.lo, 16'h000E);
        check("divu_after.hi_const", bus.hi, 16'h0002);
        run_op("div_zero_neg", 2'b11, 16'hFF85, 16'h0000);

        // second start while busy must be ignored
        model(2'b00, 16'h1234, 16'h0056, ehi, elo, edbz);
        issue(2'b00, 16'h1234, 16'h0056);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 16'h7777;
        bus.b     = 16'h0003;
        @(negedge clk);
        bus.start = 1'b0;
        n_done = 0;
        hi_s = '0;
        lo_s = '0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin
                    hi_s = bus.hi;
                    lo_s = bus.lo;
                end
            end
        end
        check("ignore.done_count", n_done, 1);
        check("ignore.hi", hi_s, ehi);
        check("ignore.lo", lo_s, elo);

        // back-to-back: the second issue lands in the done cycle of the first
        run_op("b2b_first", 2'b01, 16'h7FFF, 16'h8000);
        run_op("b2b_second", 2'b11, 16'h8001, 16'h0007);

        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom);
            ra  = W'($urandom);
            rb  = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 16'hFFFF;
                2: ra = 16'h8000;
                3: rb = W'($urandom_range(1, 9));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        // reset in the middle of a MULU aborts with no done and drops a concurrent start
        run_op("pre_abort", 2'b01, 16'hFFFD, 16'h0005);
        issue(2'b00, 16'hFFFF, 16'hFFFF);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        @(posedge clk);
        #1;
        check("abort.busy", bus.busy, 1'b0);
        check("abort.done", bus.done, 1'b0);
        check("abort.hi", bus.hi, 16'h0000);
        check("abort.lo", bus.lo, 16'h0000);
        check("abort.dbz", bus.div_by_zero, 1'b0);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
            if (bus.busy) n_busy++;
        end
        check("abort.no_done", n_done, 0);
        check("abort.start_dropped", n_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
